// File: rtl/bits_pkg.sv
// Shared definitions for the bit unpacker slice.
//   state_t        : request FSM encoding (S_IDLE / S_PEND)
//   MSB_FIRST_MODE : bit-order encoding, bits leave each word from its MSB downward
//   LSB_FIRST_MODE : bit-order encoding, bits leave each word from bit 0 upward
//   clog2()        : ceiling log2, usable in parameter expressions
package bits_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    localparam bit MSB_FIRST_MODE = 1'b0;
    localparam bit LSB_FIRST_MODE = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Count-based word FIFO with registered pointers and occupancy.
// Ports:
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset (empties the FIFO)
//   clr_i   : synchronous clear, wins over push and pop
//   push_i  : write data_i; taken when not full, or when a pop happens the same edge
//   data_i  : word to write
//   pop_i   : remove the head word (ignored when empty)
//   data_o  : head word, valid while empty_o is low
//   full_o  : occupancy equals DEPTH
//   empty_o : occupancy is zero
module word_fifo
    import bits_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !clr_i;
    assign do_push = push_i && (!full_o || do_pop) && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bit_unpacker.sv
// Word-in / variable-length-bits-out stream unpacker.
// Words enter a FIFO, are moved into a 2*INWIDTH bit buffer, and requests of
// 0..OUTWIDTH bits are served from that buffer in stream order.
// Handshake: reqin is sampled only while reqrdy=1 (FSM in S_IDLE); the result
// appears later as a single-cycle pushout strobe with lenout/dataout, which then
// hold until the next strobe. pushin has no ready: full words are dropped and ovf set.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-low reset
//   pushin, datain   : input word strobe and data
//   full, ovf        : FIFO full, sticky dropped-push flag
//   flush            : synchronous clear of FIFO, buffer, pending request and ovf
//   reqin, reqlen    : request strobe and length (clamped to OUTWIDTH)
//   reqrdy           : no request pending
//   pushout          : one-cycle result strobe
//   lenout, dataout  : result length and right-justified result bits
//   dbg_state        : current FSM state
module bit_unpacker
    import bits_pkg::*;
#(
    parameter int INWIDTH   = 32,
    parameter int OUTWIDTH  = 16,
    parameter int LENWIDTH  = 5,
    parameter int DEPTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pushin,
    input  logic [INWIDTH-1:0]  datain,
    output logic                full,
    output logic                ovf,
    input  logic                flush,
    input  logic                reqin,
    input  logic [LENWIDTH-1:0] reqlen,
    output logic                reqrdy,
    output logic                pushout,
    output logic [LENWIDTH-1:0] lenout,
    output logic [OUTWIDTH-1:0] dataout,
    output state_t              dbg_state
);

    localparam int BUFW = 2 * INWIDTH;
    localparam int CNTW = clog2(BUFW + 1);

    state_t                state_q, state_d;
    logic [BUFW-1:0]       bitbuf_q, bitbuf_d;
    logic [CNTW-1:0]       bitcnt_q, bitcnt_d;
    logic [LENWIDTH-1:0]   plen_q, plen_d;
    logic                  pushout_q, pushout_d;
    logic [LENWIDTH-1:0]   lenout_q, lenout_d;
    logic [OUTWIDTH-1:0]   dataout_q, dataout_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [INWIDTH-1:0]    fifo_data;
    logic                  refill, serve, dropped;
    logic [CNTW-1:0]       consumed, kept, out_shift;
    logic [BUFW-1:0]       word_ext, shifted, placed;
    logic [OUTWIDTH-1:0]   window, extracted;
    logic [LENWIDTH-1:0]   req_clamped;

    word_fifo #(
        .WIDTH (INWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clr_i   (flush),
        .push_i  (pushin),
        .data_i  (datain),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Refill looks at the occupancy before this edge's consume, so a word is
    // only pulled while it is guaranteed to fit behind the remaining bits.
    assign refill   = !flush && !fifo_empty && (bitcnt_q <= CNTW'(INWIDTH));
    assign fifo_pop = refill;
    assign serve    = !flush && (state_q == S_PEND) && (CNTW'(plen_q) <= bitcnt_q);
    // Flush drops a same-cycle push silently; otherwise a push into a full
    // FIFO with no simultaneous pop is lost.
    assign dropped  = pushin && !flush && fifo_full && !fifo_pop;

    assign consumed    = serve ? CNTW'(plen_q) : '0;
    assign kept        = bitcnt_q - consumed;
    assign out_shift   = CNTW'(OUTWIDTH) - CNTW'(plen_q);
    assign word_ext    = BUFW'(fifo_data);
    assign req_clamped = (reqlen > LENWIDTH'(OUTWIDTH)) ? LENWIDTH'(OUTWIDTH) : reqlen;

    // Stream order lives at the top of the buffer in MSB-first mode and at
    // bit 0 in LSB-first mode; unused buffer bits are always zero.
    always_comb begin
        shifted   = '0;
        placed    = '0;
        window    = '0;
        extracted = '0;
        if (LSB_FIRST == LSB_FIRST_MODE) begin
            shifted   = bitbuf_q >> consumed;
            placed    = word_ext << kept;
            window    = bitbuf_q[OUTWIDTH-1:0];
            extracted = window & ({OUTWIDTH{1'b1}} >> out_shift);
        end else begin
            shifted   = bitbuf_q << consumed;
            placed    = word_ext << (CNTW'(INWIDTH) - kept);
            window    = bitbuf_q[BUFW-1 -: OUTWIDTH];
            extracted = window >> out_shift;
        end
    end

    always_comb begin
        bitbuf_d = shifted | (refill ? placed : '0);
        bitcnt_d = kept + (refill ? CNTW'(INWIDTH) : '0);
        if (flush) begin
            bitbuf_d = '0;
            bitcnt_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        plen_d    = plen_q;
        pushout_d = 1'b0;
        lenout_d  = lenout_q;
        dataout_d = dataout_q;
        ovf_d     = ovf_q | dropped;
        if (flush) begin
            state_d = S_IDLE;
            plen_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (reqin) begin
                        plen_d  = req_clamped;
                        state_d = S_PEND;
                    end
                end
                S_PEND: begin
                    if (serve) begin
                        pushout_d = 1'b1;
                        lenout_d  = plen_q;
                        dataout_d = extracted;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bitbuf_q  <= '0;
            bitcnt_q  <= '0;
            plen_q    <= '0;
            pushout_q <= 1'b0;
            lenout_q  <= '0;
            dataout_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitbuf_q  <= bitbuf_d;
            bitcnt_q  <= bitcnt_d;
            plen_q    <= plen_d;
            pushout_q <= pushout_d;
            lenout_q  <= lenout_d;
            dataout_q <= dataout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign full      = fifo_full;
    assign ovf       = ovf_q;
    assign reqrdy    = (state_q == S_IDLE);
    assign pushout   = pushout_q;
    assign lenout    = lenout_q;
    assign dataout   = dataout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Bench for bit_unpacker: instance 0 is MSB-first, instance 1 is LSB-first.
module tb_bit_unpacker;
    import bits_pkg::*;

    localparam int INW  = 32;
    localparam int OUTW = 16;
    localparam int LENW = 5;
    localparam int EW   = LENW + OUTW;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic            pushin  [2];
    logic [INW-1:0]  datain  [2];
    logic            flush   [2];
    logic            reqin   [2];
    logic [LENW-1:0] reqlen  [2];
    logic            full    [2];
    logic            ovf     [2];
    logic            reqrdy  [2];
    logic            pushout [2];
    logic [LENW-1:0] lenout  [2];
    logic [OUTW-1:0] dataout [2];
    state_t          dbg_state [2];

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [INW-1:0] words [12];

    bit_unpacker #(.LSB_FIRST(1'b0)) u_msb (
        .clock(clock), .reset(reset), .pushin(pushin[0]), .datain(datain[0]),
        .full(full[0]), .ovf(ovf[0]), .flush(flush[0]), .reqin(reqin[0]),
        .reqlen(reqlen[0]), .reqrdy(reqrdy[0]), .pushout(pushout[0]),
        .lenout(lenout[0]), .dataout(dataout[0]), .dbg_state(dbg_state[0])
    );

    bit_unpacker #(.LSB_FIRST(1'b1)) u_lsb (
        .clock(clock), .reset(reset), .pushin(pushin[1]), .datain(datain[1]),
        .full(full[1]), .ovf(ovf[1]), .flush(flush[1]), .reqin(reqin[1]),
        .reqlen(reqlen[1]), .reqrdy(reqrdy[1]), .pushout(pushout[1]),
        .lenout(lenout[1]), .dataout(dataout[1]), .dbg_state(dbg_state[1])
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pushout must match the oldest queued expectation.
    always @(negedge clock) begin
        if (pushout[0] === 1'b1) begin
            logic has_exp;
            has_exp = (exp_q0.size() != 0);
            check("msb_pushout_expected", 32'(has_exp), 32'd1);
            if (has_exp) check("msb_result", 32'({lenout[0], dataout[0]}), 32'(exp_q0.pop_front()));
        end
        if (pushout[1] === 1'b1) begin
            logic has_exp;
            has_exp = (exp_q1.size() != 0);
            check("lsb_pushout_expected", 32'(has_exp), 32'd1);
            if (has_exp) check("lsb_result", 32'({lenout[1], dataout[1]}), 32'(exp_q1.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input int d, input logic [INW-1:0] w);
        pushin[d] = 1'b1;
        datain[d] = w;
        tick();
        pushin[d] = 1'b0;
    endtask

    task automatic do_flush(input int d);
        flush[d] = 1'b1;
        tick();
        flush[d] = 1'b0;
    endtask

    task automatic request(input int d, input logic [LENW-1:0] len,
                           input logic [LENW-1:0] exp_len, input logic [OUTW-1:0] exp_data);
        int n;
        n = 0;
        while (reqrdy[d] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("reqrdy_wait", 32'(reqrdy[d]), 32'd1);
        if (d == 0) exp_q0.push_back({exp_len, exp_data});
        else        exp_q1.push_back({exp_len, exp_data});
        reqin[d]  = 1'b1;
        reqlen[d] = len;
        tick();
        reqin[d]  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_q0", 32'(exp_q0.size()), 32'd0);
        check("drain_q1", 32'(exp_q1.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pushout"}, 32'(pushout[0]), 32'd0);
        check({tag, "_lenout"},  32'(lenout[0]),  32'd0);
        check({tag, "_dataout"}, 32'(dataout[0]), 32'd0);
        check({tag, "_full"},    32'(full[0]),    32'd0);
        check({tag, "_ovf"},     32'(ovf[0]),     32'd0);
        check({tag, "_reqrdy"},  32'(reqrdy[0]),  32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            pushin[i] = 1'b0; datain[i] = '0; flush[i] = 1'b0;
            reqin[i]  = 1'b0; reqlen[i] = '0;
        end
        for (int i = 0; i < 12; i++) words[i] = $urandom_range(32'hFFFF_FFFF, 0);
        reset = 1'b0;
        repeat (3) tick();
        check_reset_values("por");
        reset = 1'b1;
        tick();

        // Word split across three requests.
        push_word(0, 32'hDEADBEEF);
        request(0, 5'd4,  5'd4,  16'h000D);
        request(0, 5'd12, 5'd12, 16'h0EAD);
        request(0, 5'd16, 5'd16, 16'hBEEF);
        wait_drain();

        // Requests straddling a word boundary; 28 bits remain afterwards.
        push_word(0, 32'h12345678);
        push_word(0, 32'h9ABCDEF0);
        request(0, 5'd16, 5'd16, 16'h1234);
        request(0, 5'd12, 5'd12, 16'h0567);
        request(0, 5'd8,  5'd8,  16'h0089);
        wait_drain();

        // Reset while a request is pending: it must vanish along with the buffer.
        reqin[0]  = 1'b1;
        reqlen[0] = 5'd8;
        tick();
        reqin[0]  = 1'b0;
        check("abort_pending", 32'(reqrdy[0]), 32'd0);
        reset = 1'b0;
        #1;
        check_reset_values("abort");
        tick();
        reset = 1'b1;
        repeat (5) tick();
        push_word(0, 32'h5A000000);
        request(0, 5'd4, 5'd4, 16'h0005);
        wait_drain();

        // Starved request, then a word arrives.
        do_flush(0);
        request(0, 5'd8, 5'd8, 16'h00FF);
        for (int i = 0; i < 5; i++) begin
            check("starve_reqrdy",  32'(reqrdy[0]),  32'd0);
            check("starve_pushout", 32'(pushout[0]), 32'd0);
            tick();
        end
        push_word(0, 32'hFF000000);
        check("starve_n1_pushout", 32'(pushout[0]), 32'd0);
        tick();
        check("starve_n2_pushout", 32'(pushout[0]), 32'd0);
        tick();
        check("starve_n3_pushout", 32'(pushout[0]), 32'd1);
        check("starve_dataout",    32'(dataout[0]), 32'h00FF);
        wait_drain();

        // Zero-length and over-length requests.
        do_flush(0);
        push_word(0, 32'hC3C35A5A);
        request(0, 5'd0,  5'd0,  16'h0000);
        request(0, 5'd31, 5'd16, 16'hC3C3);
        request(0, 5'd16, 5'd16, 16'h5A5A);
        wait_drain();

        // Overflow: 12 pushes, 10 kept (8 in FIFO, 2 in the bit buffer).
        do_flush(0);
        for (int i = 0; i < 12; i++) push_word(0, words[i]);
        check("ovf_full", 32'(full[0]), 32'd1);
        check("ovf_set",  32'(ovf[0]),  32'd1);
        for (int i = 0; i < 10; i++) begin
            request(0, 5'd16, 5'd16, words[i][31:16]);
            request(0, 5'd16, 5'd16, words[i][15:0]);
        end
        wait_drain();
        check("ovf_sticky",  32'(ovf[0]),    32'd1);
        check("drained_rdy", 32'(reqrdy[0]), 32'd1);
        do_flush(0);
        check("flush_ovf",  32'(ovf[0]),  32'd0);
        check("flush_full", 32'(full[0]), 32'd0);

        // LSB-first ordering.
        push_word(1, 32'h12345678);
        request(1, 5'd4, 5'd4, 16'h0008);
        request(1, 5'd8, 5'd8, 16'h0067);
        wait_drain();

        // Flush while a request is pending (20 bits would have satisfied it).
        reqin[1]  = 1'b1;
        reqlen[1] = 5'd16;
        tick();
        reqin[1]  = 1'b0;
        check("lsb_pend", 32'(reqrdy[1]), 32'd0);
        flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        check("lsb_flush_reqrdy",  32'(reqrdy[1]),  32'd1);
        check("lsb_flush_pushout", 32'(pushout[1]), 32'd0);
        repeat (4) tick();
        push_word(1, 32'hAABBCCDD);
        request(1, 5'd8, 5'd8, 16'h00DD);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
